// File: rtl/sort_pkt_scheduler.sv
// rtl/sort_pkt_scheduler.sv - spreads whole packets over two sorter lanes and
// re-merges the sorted packets in arrival order using a 1-bit lane-id FIFO.
module sort_pkt_scheduler #(
   parameter int DWIDTH      = 16,
   parameter int MAX_PKT_LEN = 13,
   parameter int ORDER_DEPTH = 4
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic [DWIDTH-1:0]   snk_data_i,
   input  logic                snk_startofpacket_i,
   input  logic                snk_endofpacket_i,
   input  logic                snk_valid_i,
   output logic                snk_ready_o,
   output logic [2*DWIDTH-1:0] lane_snk_data_o,
   output logic [1:0]          lane_snk_startofpacket_o,
   output logic [1:0]          lane_snk_endofpacket_o,
   output logic [1:0]          lane_snk_valid_o,
   input  logic [1:0]          lane_snk_ready_i,
   input  logic [2*DWIDTH-1:0] lane_src_data_i,
   input  logic [1:0]          lane_src_startofpacket_i,
   input  logic [1:0]          lane_src_endofpacket_i,
   input  logic [1:0]          lane_src_valid_i,
   output logic [1:0]          lane_src_ready_o,
   output logic [DWIDTH-1:0]   src_data_o,
   output logic                src_startofpacket_o,
   output logic                src_endofpacket_o,
   output logic                src_valid_o,
   input  logic                src_ready_i,
   output logic                drop_o
);

   localparam int AW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
   localparam int CW = $clog2(ORDER_DEPTH) + 1;
   localparam int BW = $clog2(MAX_PKT_LEN + 1);

   typedef enum logic {IN_IDLE, IN_PKT} in_state_t;

   in_state_t         state_q, state_d;
   logic              rr_q, rr_d;
   logic              cur_lane_q, cur_lane_d;
   logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
   logic              trunc_q, trunc_d;

   logic              order_mem [ORDER_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;

   logic              sel_ok, sel_lane, fifo_full, fifo_empty;
   logic              push, pop, head;
   logic              ready_int, drop_int, last_beat;
   logic [1:0]        lane_valid, lane_sop, lane_eop;

   assign sel_ok     = lane_snk_ready_i[rr_q] || lane_snk_ready_i[~rr_q];
   assign sel_lane   = lane_snk_ready_i[rr_q] ? rr_q : ~rr_q;
   assign fifo_full  = (count_q == CW'(ORDER_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign last_beat  = (beat_cnt_q == BW'(MAX_PKT_LEN - 1));

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      cur_lane_d = cur_lane_q;
      beat_cnt_d = beat_cnt_q;
      trunc_d    = trunc_q;
      ready_int  = 1'b0;
      drop_int   = 1'b0;
      push       = 1'b0;
      lane_valid = '0;
      lane_sop   = '0;
      lane_eop   = '0;
      case (state_q)
         IN_IDLE: begin
            if (snk_valid_i && !snk_startofpacket_i) begin
               // stray mid-packet beats are swallowed so upstream never stalls on them
               ready_int = 1'b1;
               drop_int  = 1'b1;
            end else begin
               ready_int = sel_ok && !fifo_full;
               if (snk_valid_i && ready_int) begin
                  lane_valid[sel_lane] = 1'b1;
                  lane_sop[sel_lane]   = 1'b1;
                  lane_eop[sel_lane]   = snk_endofpacket_i || (MAX_PKT_LEN == 1);
                  push       = 1'b1;
                  rr_d       = ~sel_lane;
                  cur_lane_d = sel_lane;
                  beat_cnt_d = BW'(1);
                  if (!snk_endofpacket_i) begin
                     state_d = IN_PKT;
                     trunc_d = (MAX_PKT_LEN == 1);
                  end
               end
            end
         end
         IN_PKT: begin
            if (trunc_q) begin
               // lane packet already closed; discard the rest of the upstream packet
               ready_int = 1'b1;
               if (snk_valid_i) begin
                  drop_int = 1'b1;
                  if (snk_endofpacket_i) begin
                     state_d = IN_IDLE;
                     trunc_d = 1'b0;
                  end
               end
            end else begin
               ready_int              = lane_snk_ready_i[cur_lane_q];
               lane_valid[cur_lane_q] = snk_valid_i;
               lane_sop[cur_lane_q]   = snk_startofpacket_i;
               lane_eop[cur_lane_q]   = snk_endofpacket_i || last_beat;
               if (snk_valid_i && ready_int) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
                  if (snk_endofpacket_i) begin
                     state_d = IN_IDLE;
                  end else if (last_beat) begin
                     trunc_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IN_IDLE;
      endcase
   end

   assign snk_ready_o              = arst_n_i && ready_int;
   assign drop_o                   = arst_n_i && drop_int;
   assign lane_snk_valid_o         = {2{arst_n_i}} & lane_valid;
   assign lane_snk_startofpacket_o = lane_sop;
   assign lane_snk_endofpacket_o   = lane_eop;
   assign lane_snk_data_o          = {snk_data_i, snk_data_i};

   assign head                = order_mem[rd_ptr_q];
   assign src_data_o          = head ? lane_src_data_i[DWIDTH +: DWIDTH] : lane_src_data_i[0 +: DWIDTH];
   assign src_startofpacket_o = lane_src_startofpacket_i[head];
   assign src_endofpacket_o   = lane_src_endofpacket_i[head];
   assign src_valid_o         = !fifo_empty && lane_src_valid_i[head];
   assign lane_src_ready_o    = fifo_empty ? 2'b00 : (head ? {src_ready_i, 1'b0} : {1'b0, src_ready_i});
   assign pop                 = src_valid_o && src_ready_i && src_endofpacket_o;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= IN_IDLE;
         rr_q       <= 1'b0;
         cur_lane_q <= 1'b0;
         beat_cnt_q <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         cur_lane_q <= cur_lane_d;
         beat_cnt_q <= beat_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == AW'(ORDER_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == AW'(ORDER_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // lane-id storage needs no reset: entries are only read when count_q says they are valid
   always_ff @(posedge clk_i) begin
      if (push) begin
         order_mem[wr_ptr_q] <= sel_lane;
      end
   end

endmodule

// File: tb/tb_sort_pkt_scheduler.sv
// tb/tb_sort_pkt_scheduler.sv - directed scoreboard bench for sort_pkt_scheduler
// with a behavioural two-lane sorter model of configurable latency.
module tb_sort_pkt_scheduler;

   localparam int DW = 16;

   typedef struct {
      logic [DW-1:0] d;
      logic          s;
      logic          e;
      int            t;
   } beat_t;

   logic            clk_i = 1'b0;
   logic            arst_n_i;
   logic [DW-1:0]   snk_data_i;
   logic            snk_startofpacket_i, snk_endofpacket_i, snk_valid_i;
   logic            snk_ready_o;
   logic [2*DW-1:0] lane_snk_data_o;
   logic [1:0]      lane_snk_startofpacket_o, lane_snk_endofpacket_o, lane_snk_valid_o;
   logic [1:0]      lane_snk_ready_i;
   logic [2*DW-1:0] lane_src_data_i;
   logic [1:0]      lane_src_startofpacket_i, lane_src_endofpacket_i, lane_src_valid_i;
   logic [1:0]      lane_src_ready_o;
   logic [DW-1:0]   src_data_o;
   logic            src_startofpacket_o, src_endofpacket_o, src_valid_o;
   logic            src_ready_i;
   logic            drop_o;

   sort_pkt_scheduler #(.DWIDTH(DW), .MAX_PKT_LEN(13), .ORDER_DEPTH(4)) dut (
      .clk_i                   (clk_i),
      .arst_n_i                (arst_n_i),
      .snk_data_i              (snk_data_i),
      .snk_startofpacket_i     (snk_startofpacket_i),
      .snk_endofpacket_i       (snk_endofpacket_i),
      .snk_valid_i             (snk_valid_i),
      .snk_ready_o             (snk_ready_o),
      .lane_snk_data_o         (lane_snk_data_o),
      .lane_snk_startofpacket_o(lane_snk_startofpacket_o),
      .lane_snk_endofpacket_o  (lane_snk_endofpacket_o),
      .lane_snk_valid_o        (lane_snk_valid_o),
      .lane_snk_ready_i        (lane_snk_ready_i),
      .lane_src_data_i         (lane_src_data_i),
      .lane_src_startofpacket_i(lane_src_startofpacket_i),
      .lane_src_endofpacket_i  (lane_src_endofpacket_i),
      .lane_src_valid_i        (lane_src_valid_i),
      .lane_src_ready_o        (lane_src_ready_o),
      .src_data_o              (src_data_o),
      .src_startofpacket_o     (src_startofpacket_o),
      .src_endofpacket_o       (src_endofpacket_o),
      .src_valid_o             (src_valid_o),
      .src_ready_i             (src_ready_i),
      .drop_o                  (drop_o)
   );

   always #5 clk_i = ~clk_i;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_q [$];

   logic [1:0] cap_v, cap_sop, cap_eop;
   logic       cap_drop;

   int            lat [2];
   int            cyc = 0;
   logic [DW-1:0] ib [2][16];
   int            ic [2];
   beat_t         oq0 [$];
   beat_t         oq1 [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout, expected completion", name);
   endtask

   task automatic exp_push(input logic [DW-1:0] d, input logic s, input logic e);
      beat_t b;
      b.d = d; b.s = s; b.e = e; b.t = 0;
      exp_q.push_back(b);
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
      bit done;
      done = 1'b0;
      snk_data_i = d; snk_startofpacket_i = s; snk_endofpacket_i = e; snk_valid_i = 1'b1;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk_i);
         if (snk_ready_o) begin
            done     = 1'b1;
            cap_v    = lane_snk_valid_o;
            cap_sop  = lane_snk_startofpacket_o;
            cap_eop  = lane_snk_endofpacket_o;
            cap_drop = drop_o;
         end
         @(posedge clk_i); #1;
      end
      snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
      if (!done) timeout_fail("send_beat");
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk_i);
         if (exp_q.size() == 0) ok = 1'b1;
      end
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      if (!ok) timeout_fail("drain");
   endtask

   // Sorter lane model: collects a packet, sorts it ascending, replays it after lat[k] cycles.
   initial begin
      logic [1:0]    in_x, out_x, in_e;
      logic [DW-1:0] in_d [2];
      beat_t         b;
      logic [DW-1:0] tmp;
      ic[0] = 0; ic[1] = 0;
      lane_src_valid_i = 2'b00; lane_src_data_i = '0;
      lane_src_startofpacket_i = 2'b00; lane_src_endofpacket_i = 2'b00;
      forever begin
         @(negedge clk_i);
         for (int k = 0; k < 2; k++) begin
            in_x[k]  = lane_snk_valid_o[k] && lane_snk_ready_i[k];
            in_e[k]  = lane_snk_endofpacket_o[k];
            in_d[k]  = lane_snk_data_o[k*DW +: DW];
            out_x[k] = lane_src_valid_i[k] && lane_src_ready_o[k];
         end
         @(posedge clk_i); #1;
         cyc++;
         if (!arst_n_i) begin
            oq0.delete(); oq1.delete(); ic[0] = 0; ic[1] = 0;
         end else begin
            if (out_x[0]) b = oq0.pop_front();
            if (out_x[1]) b = oq1.pop_front();
            for (int k = 0; k < 2; k++) begin
               if (in_x[k] && ic[k] < 16) begin
                  ib[k][ic[k]] = in_d[k];
                  ic[k]++;
                  if (in_e[k]) begin
                     for (int i = 0; i < ic[k]; i++)
                        for (int j = 0; j + 1 < ic[k] - i; j++)
                           if (ib[k][j] > ib[k][j+1]) begin
                              tmp = ib[k][j]; ib[k][j] = ib[k][j+1]; ib[k][j+1] = tmp;
                           end
                     for (int i = 0; i < ic[k]; i++) begin
                        b.d = ib[k][i]; b.s = (i == 0); b.e = (i == ic[k] - 1); b.t = cyc + lat[k];
                        if (k == 0) oq0.push_back(b); else oq1.push_back(b);
                     end
                     ic[k] = 0;
                  end
               end
            end
         end
         lane_src_valid_i = 2'b00;
         if (oq0.size() > 0 && oq0[0].t <= cyc) begin
            lane_src_valid_i[0] = 1'b1; lane_src_data_i[0 +: DW] = oq0[0].d;
            lane_src_startofpacket_i[0] = oq0[0].s; lane_src_endofpacket_i[0] = oq0[0].e;
         end
         if (oq1.size() > 0 && oq1[0].t <= cyc) begin
            lane_src_valid_i[1] = 1'b1; lane_src_data_i[DW +: DW] = oq1[0].d;
            lane_src_startofpacket_i[1] = oq1[0].s; lane_src_endofpacket_i[1] = oq1[0].e;
         end
      end
   end

   // Scoreboard monitor
   initial begin
      beat_t e;
      forever begin
         @(negedge clk_i);
         if (arst_n_i && src_valid_o && src_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL src_unexpected: got data %0h, expected no output", src_data_o);
            end else begin
               e = exp_q.pop_front();
               chk("src_beat", {src_startofpacket_o, src_endofpacket_o, src_data_o}, {e.s, e.e, e.d});
            end
         end
      end
   end

   initial begin
      arst_n_i = 1'b0;
      snk_data_i = 16'h0; snk_startofpacket_i = 1'b1; snk_endofpacket_i = 1'b0; snk_valid_i = 1'b1;
      lane_snk_ready_i = 2'b11; src_ready_i = 1'b1;
      lat[0] = 2; lat[1] = 2;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_snk_ready", snk_ready_o, 0);
      chk("rst_src_valid", src_valid_o, 0);
      chk("rst_lane_snk_valid", lane_snk_valid_o, 0);
      chk("rst_lane_src_ready", lane_src_ready_o, 0);
      @(posedge clk_i); #1;
      arst_n_i = 1'b1; snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0;
      @(posedge clk_i); #1;

      // {5,1,3} -> lane0, sorted {1,3,5}
      exp_push(16'd1, 1, 0); exp_push(16'd3, 0, 0); exp_push(16'd5, 0, 1);
      send_beat(16'd5, 1, 0);
      chk("p1_first_lane", cap_v, 2'b01);
      chk("p1_first_sop", cap_sop, 2'b01);
      send_beat(16'd1, 0, 0);
      send_beat(16'd3, 0, 1);
      chk("p1_last_eop", cap_eop & cap_v, 2'b01);
      wait_drain();
      exp_push(16'd7, 1, 1);
      send_beat(16'd7, 1, 1);
      chk("p2_rr_lane1", cap_v, 2'b10);
      wait_drain();

      // A on slow lane0, B on fast lane1: B must wait behind A
      lat[0] = 30; lat[1] = 1;
      exp_push(16'd8, 1, 0); exp_push(16'd9, 0, 1);
      exp_push(16'd2, 1, 0); exp_push(16'd4, 0, 0); exp_push(16'd6, 0, 1);
      send_beat(16'd9, 1, 0); send_beat(16'd8, 0, 1);
      send_beat(16'd4, 1, 0);
      chk("p3_b_lane1", cap_v, 2'b10);
      send_beat(16'd2, 0, 0); send_beat(16'd6, 0, 1);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_i);
         if (lane_src_valid_i[1]) break;
      end
      chk("p3_b_held", lane_src_ready_o[1], 0);
      chk("p3_a_not_ready", src_valid_o, 0);
      @(posedge clk_i); #1;
      wait_drain();
      lat[0] = 2; lat[1] = 2;

      // only lane1 ready while rr_ptr=0
      lane_snk_ready_i = 2'b10;
      exp_push(16'd11, 1, 1); exp_push(16'd12, 1, 1);
      send_beat(16'd11, 1, 1);
      chk("p4_forced_lane1", cap_v, 2'b10);
      lane_snk_ready_i = 2'b11;
      send_beat(16'd12, 1, 1);
      chk("p4_rr_stays0", cap_v, 2'b01);
      lane_snk_ready_i = 2'b00;
      snk_valid_i = 1'b1; snk_startofpacket_i = 1'b1; snk_endofpacket_i = 1'b1;
      @(negedge clk_i);
      chk("p4_no_lane_ready", snk_ready_o, 0);
      @(posedge clk_i); #1;
      snk_valid_i = 1'b0; lane_snk_ready_i = 2'b11;
      wait_drain();

      // fill the order FIFO with downstream stalled
      src_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_push(DW'(20 + i), 1, 1);
         send_beat(DW'(20 + i), 1, 1);
      end
      snk_data_i = 16'd24; snk_startofpacket_i = 1'b1; snk_endofpacket_i = 1'b1; snk_valid_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("p5_full_blocks", snk_ready_o, 0);
      @(posedge clk_i); #1;
      src_ready_i = 1'b1;
      exp_push(16'd24, 1, 1);
      send_beat(16'd24, 1, 1);
      wait_drain();

      // stray beat in idle, then a 15-word packet truncated at 13
      send_beat(16'h55, 0, 0);
      chk("p6_stray_drop", cap_drop, 1);
      chk("p6_stray_no_lane", cap_v, 0);
      @(negedge clk_i);
      chk("p6_drop_one_cycle", drop_o, 0);
      @(posedge clk_i); #1;
      for (int i = 13; i >= 1; i--) exp_push(DW'(200 - 3*i), i == 13, i == 1);
      for (int i = 1; i <= 15; i++) begin
         send_beat(DW'(200 - 3*i), i == 1, i == 15);
         if (i == 12) chk("p6_w12_no_eop", cap_eop & cap_v, 0);
         if (i == 13) chk("p6_w13_forced_eop", (cap_eop & cap_v) != 0, 1);
         if (i >= 14) begin
            chk("p6_tail_drop", cap_drop, 1);
            chk("p6_tail_no_lane", cap_v, 0);
         end
      end
      wait_drain();

      // reset during word 2 of a packet
      send_beat(16'd30, 1, 0);
      snk_data_i = 16'd31; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0; snk_valid_i = 1'b1;
      @(negedge clk_i);
      arst_n_i = 1'b0;
      #1;
      chk("p7_rst_snk_ready", snk_ready_o, 0);
      chk("p7_rst_lane_valid", lane_snk_valid_o, 0);
      chk("p7_rst_src_valid", src_valid_o, 0);
      chk("p7_rst_lane_src_ready", lane_src_ready_o, 0);
      snk_valid_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      arst_n_i = 1'b1;
      @(posedge clk_i); #1;
      exp_push(16'd42, 1, 1);
      send_beat(16'd42, 1, 1);
      chk("p7_after_rst_lane0", cap_v, 2'b01);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
